// File: rtl/regfile_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_writeback_ctrl
//
// Write-side master for the register file. Collects results from the ALU
// (through a small FIFO) and from the load unit (through a single holding
// register), then issues at most one register-file write per cycle.
// Decode uses pend_mask to stall on read-after-write hazards.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; discards all buffered results
//   alu_valid  ALU result valid
//   alu_rd     ALU destination register
//   alu_data   ALU result data
//   alu_ready  ALU FIFO can accept (not full)
//   mem_valid  load result valid
//   mem_rd     load destination register
//   mem_data   load data
//   mem_ready  holding register can accept (empty or draining this cycle)
//   regWrite   register-file write enable, one pulse per write
//   select     1: address on rd1 (ALU), 0: address on rd2 (mem)
//   rd1        ALU write address
//   rd2        mem write address
//   WriteData  write data
//   pend_mask  bit i set while a write to register i is buffered or issuing
// ---------------------------------------------------------------------------
module regfile_writeback_ctrl #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 4,
  parameter int ALU_DEPTH      = 2,
  parameter int MAX_MEM_STREAK = 3,
  parameter int R0_HARDWIRED   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [ADDR_W-1:0]      mem_rd,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   mem_ready,
  output logic                   regWrite,
  output logic                   select,
  output logic [ADDR_W-1:0]      rd1,
  output logic [ADDR_W-1:0]      rd2,
  output logic [DATA_W-1:0]      WriteData,
  output logic [2**ADDR_W-1:0]   pend_mask
);

  localparam int PTR_W    = (ALU_DEPTH > 1) ? $clog2(ALU_DEPTH) : 1;
  localparam int CNT_W    = PTR_W + 1;
  localparam int STREAK_W = $clog2(MAX_MEM_STREAK + 1);
  localparam int NREG     = 2**ADDR_W;

  // ALU FIFO storage and pointers
  logic [ADDR_W-1:0]   fifoRd     [ALU_DEPTH];
  logic [DATA_W-1:0]   fifoData   [ALU_DEPTH];
  logic [PTR_W-1:0]    wrPtr;
  logic [PTR_W-1:0]    rdPtr;
  logic [CNT_W-1:0]    fifoCount;

  // Load-result holding register
  logic                holdValid;
  logic [ADDR_W-1:0]   holdRd;
  logic [DATA_W-1:0]   holdData;

  // Consecutive mem grants while ALU work is waiting
  logic [STREAK_W-1:0] streak;

  // Next-state values
  logic [ADDR_W-1:0]   fifoRdNext   [ALU_DEPTH];
  logic [DATA_W-1:0]   fifoDataNext [ALU_DEPTH];
  logic [PTR_W-1:0]    wrPtrNext;
  logic [PTR_W-1:0]    rdPtrNext;
  logic [CNT_W-1:0]    countNext;
  logic                holdValidNext;
  logic [ADDR_W-1:0]   holdRdNext;
  logic [DATA_W-1:0]   holdDataNext;
  logic [STREAK_W-1:0] streakNext;
  logic                outValidNext;
  logic [ADDR_W-1:0]   outRdNext;
  logic [NREG-1:0]     pendNext;
  logic [PTR_W-1:0]    entryIdx;

  // Arbitration and handshake terms, all from registered state
  logic fifoFull;
  logic fifoNonEmpty;
  logic streakMax;
  logic memGrant;
  logic aluGrant;
  logic aluIsR0;
  logic memIsR0;
  logic aluPush;
  logic memPush;

  assign fifoFull     = (fifoCount == CNT_W'(ALU_DEPTH));
  assign fifoNonEmpty = (fifoCount != {CNT_W{1'b0}});
  assign streakMax    = (streak == STREAK_W'(MAX_MEM_STREAK));

  // The streak cap only bites when ALU work is actually waiting.
  assign memGrant  = holdValid && !(fifoNonEmpty && streakMax);
  assign aluGrant  = fifoNonEmpty && !memGrant;

  assign alu_ready = !fifoFull;
  assign mem_ready = !holdValid || memGrant;

  // Writes to r0 complete the handshake but are dropped here.
  assign aluIsR0 = (R0_HARDWIRED != 0) && (alu_rd == {ADDR_W{1'b0}});
  assign memIsR0 = (R0_HARDWIRED != 0) && (mem_rd == {ADDR_W{1'b0}});
  assign aluPush = alu_valid && alu_ready && !aluIsR0;
  assign memPush = mem_valid && mem_ready && !memIsR0;

  // Next-state computation for FIFO, holding register, streak and pend mask
  always_comb begin
    fifoRdNext    = fifoRd;
    fifoDataNext  = fifoData;
    wrPtrNext     = wrPtr;
    rdPtrNext     = rdPtr;
    countNext     = fifoCount;
    holdValidNext = holdValid;
    holdRdNext    = holdRd;
    holdDataNext  = holdData;
    streakNext    = streak;
    outValidNext  = 1'b0;
    outRdNext     = {ADDR_W{1'b0}};
    pendNext      = {NREG{1'b0}};
    entryIdx      = {PTR_W{1'b0}};

    if (aluPush) begin
      fifoRdNext[wrPtr]   = alu_rd;
      fifoDataNext[wrPtr] = alu_data;
      wrPtrNext           = wrPtr + PTR_W'(1'b1);
    end else begin
      wrPtrNext = wrPtr;
    end

    if (aluGrant) begin
      rdPtrNext = rdPtr + PTR_W'(1'b1);
    end else begin
      rdPtrNext = rdPtr;
    end

    case ({aluPush, aluGrant})
      2'b10:   countNext = fifoCount + CNT_W'(1'b1);
      2'b01:   countNext = fifoCount - CNT_W'(1'b1);
      default: countNext = fifoCount;
    endcase

    // A refill on the draining edge keeps the holding register occupied.
    if (memPush) begin
      holdValidNext = 1'b1;
      holdRdNext    = mem_rd;
      holdDataNext  = mem_data;
    end else if (memGrant) begin
      holdValidNext = 1'b0;
    end else begin
      holdValidNext = holdValid;
    end

    if (aluGrant || !fifoNonEmpty) begin
      streakNext = {STREAK_W{1'b0}};
    end else if (memGrant && !streakMax) begin
      streakNext = streak + STREAK_W'(1'b1);
    end else begin
      streakNext = streak;
    end

    if (memGrant) begin
      outValidNext = 1'b1;
      outRdNext    = holdRd;
    end else if (aluGrant) begin
      outValidNext = 1'b1;
      outRdNext    = fifoRd[rdPtr];
    end else begin
      outValidNext = 1'b0;
    end

    // Pending = every entry still buffered after this edge, plus the one issuing.
    for (int i = 0; i < ALU_DEPTH; i++) begin
      entryIdx = rdPtrNext + PTR_W'(i);
      if (CNT_W'(i) < countNext) begin
        pendNext[fifoRdNext[entryIdx]] = 1'b1;
      end else begin
        pendNext = pendNext;
      end
    end
    if (holdValidNext) begin
      pendNext[holdRdNext] = 1'b1;
    end else begin
      pendNext = pendNext;
    end
    if (outValidNext) begin
      pendNext[outRdNext] = 1'b1;
    end else begin
      pendNext = pendNext;
    end
  end

  // Buffer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ALU_DEPTH; i++) begin
        fifoRd[i]   <= {ADDR_W{1'b0}};
        fifoData[i] <= {DATA_W{1'b0}};
      end
      wrPtr     <= {PTR_W{1'b0}};
      rdPtr     <= {PTR_W{1'b0}};
      fifoCount <= {CNT_W{1'b0}};
      holdValid <= 1'b0;
      holdRd    <= {ADDR_W{1'b0}};
      holdData  <= {DATA_W{1'b0}};
      streak    <= {STREAK_W{1'b0}};
    end else begin
      fifoRd    <= fifoRdNext;
      fifoData  <= fifoDataNext;
      wrPtr     <= wrPtrNext;
      rdPtr     <= rdPtrNext;
      fifoCount <= countNext;
      holdValid <= holdValidNext;
      holdRd    <= holdRdNext;
      holdData  <= holdDataNext;
      streak    <= streakNext;
    end
  end

  // Registered register-file write port and hazard mask
  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite  <= 1'b0;
      select    <= 1'b0;
      rd1       <= {ADDR_W{1'b0}};
      rd2       <= {ADDR_W{1'b0}};
      WriteData <= {DATA_W{1'b0}};
      pend_mask <= {NREG{1'b0}};
    end else begin
      regWrite  <= outValidNext;
      pend_mask <= pendNext;
      if (memGrant) begin
        select    <= 1'b0;
        rd2       <= holdRd;
        WriteData <= holdData;
      end else if (aluGrant) begin
        select    <= 1'b1;
        rd1       <= fifoRd[rdPtr];
        WriteData <= fifoData[rdPtr];
      end else begin
        select    <= select;
        rd1       <= rd1;
        rd2       <= rd2;
        WriteData <= WriteData;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
module tb_regfile_writeback_ctrl;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_rd;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        regWrite;
  logic        select;
  logic [3:0]  rd1;
  logic [3:0]  rd2;
  logic [15:0] WriteData;
  logic [15:0] pend_mask;

  int passCnt;
  int totalCnt;

  regfile_writeback_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .regWrite  (regWrite),
    .select    (select),
    .rd1       (rd1),
    .rd2       (rd2),
    .WriteData (WriteData),
    .pend_mask (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkWrite(input string tag, input logic expSel, input logic [3:0] expRd,
                          input logic [15:0] expData, input logic [15:0] expPend);
    chk({tag, ".regWrite"}, {31'd0, regWrite}, 32'd1);
    chk({tag, ".select"}, {31'd0, select}, {31'd0, expSel});
    if (expSel) chk({tag, ".rd1"}, {28'd0, rd1}, {28'd0, expRd});
    else        chk({tag, ".rd2"}, {28'd0, rd2}, {28'd0, expRd});
    chk({tag, ".data"}, {16'd0, WriteData}, {16'd0, expData});
    chk({tag, ".pend"}, {16'd0, pend_mask}, {16'd0, expPend});
  endtask

  task automatic chkIdle(input string tag, input logic [15:0] expPend);
    chk({tag, ".regWrite"}, {31'd0, regWrite}, 32'd0);
    chk({tag, ".pend"}, {16'd0, pend_mask}, {16'd0, expPend});
  endtask

  initial begin
    passCnt   = 0;
    totalCnt  = 0;
    reset     = 1'b1;
    alu_valid = 1'b1;
    alu_rd    = 4'd3;
    alu_data  = 16'h1234;
    mem_valid = 1'b0;
    mem_rd    = 4'd0;
    mem_data  = 16'h0000;

    // 1. Reset held two cycles with alu_valid asserted
    tick();
    chkIdle("rst1", 16'h0000);
    tick();
    chkIdle("rst2", 16'h0000);
    chk("rst.select", {31'd0, select}, 32'd0);
    chk("rst.rd1", {28'd0, rd1}, 32'd0);
    chk("rst.rd2", {28'd0, rd2}, 32'd0);
    chk("rst.data", {16'd0, WriteData}, 32'd0);
    reset     = 1'b0;
    alu_valid = 1'b0;
    tick();
    chkIdle("rst.rel", 16'h0000);
    chk("rst.alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst.mem_ready", {31'd0, mem_ready}, 32'd1);

    // 2. ALU only, back-to-back pushes
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 16'h0001;
    tick();
    chkIdle("alu.acc", 16'h0002);
    alu_rd = 4'd3; alu_data = 16'h0003;
    tick();
    chkWrite("alu.w1", 1'b1, 4'd1, 16'h0001, 16'h000A);
    alu_rd = 4'd5; alu_data = 16'h0005;
    tick();
    chkWrite("alu.w3", 1'b1, 4'd3, 16'h0003, 16'h0028);
    alu_valid = 1'b0;
    tick();
    chkWrite("alu.w5", 1'b1, 4'd5, 16'h0005, 16'h0020);
    tick();
    chkIdle("alu.end", 16'h0000);
    chk("alu.end.rd1hold", {28'd0, rd1}, 32'd5);
    chk("alu.end.selhold", {31'd0, select}, 32'd1);

    // 3. Mem only, streaming
    mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 16'h0002;
    tick();
    chkIdle("mem.acc", 16'h0004);
    chk("mem.ready", {31'd0, mem_ready}, 32'd1);
    mem_rd = 4'd4; mem_data = 16'h0004;
    tick();
    chkWrite("mem.w2", 1'b0, 4'd2, 16'h0002, 16'h0014);
    mem_rd = 4'd6; mem_data = 16'h0006;
    tick();
    chkWrite("mem.w4", 1'b0, 4'd4, 16'h0004, 16'h0050);
    mem_rd = 4'd8; mem_data = 16'h0008;
    tick();
    chkWrite("mem.w6", 1'b0, 4'd6, 16'h0006, 16'h0140);
    mem_valid = 1'b0;
    tick();
    chkWrite("mem.w8", 1'b0, 4'd8, 16'h0008, 16'h0100);
    tick();
    chkIdle("mem.end", 16'h0000);

    // 4. Contention: one ALU entry against a 5-result mem stream
    alu_valid = 1'b1; alu_rd = 4'd7;  alu_data = 16'hAAAA;
    mem_valid = 1'b1; mem_rd = 4'd10; mem_data = 16'h0010;
    tick();
    chkIdle("con.acc", 16'h0480);
    alu_valid = 1'b0;
    mem_rd = 4'd11; mem_data = 16'h0011;
    tick();
    chkWrite("con.m10", 1'b0, 4'd10, 16'h0010, 16'h0C80);
    mem_rd = 4'd12; mem_data = 16'h0012;
    tick();
    chkWrite("con.m11", 1'b0, 4'd11, 16'h0011, 16'h1880);
    mem_rd = 4'd13; mem_data = 16'h0013;
    tick();
    chkWrite("con.m12", 1'b0, 4'd12, 16'h0012, 16'h3080);
    chk("con.memStall", {31'd0, mem_ready}, 32'd0);
    mem_rd = 4'd14; mem_data = 16'h0014;
    tick();
    chkWrite("con.alu7", 1'b1, 4'd7, 16'hAAAA, 16'h2080);
    chk("con.memReady", {31'd0, mem_ready}, 32'd1);
    tick();
    chkWrite("con.m13", 1'b0, 4'd13, 16'h0013, 16'h6000);
    mem_valid = 1'b0;
    tick();
    chkWrite("con.m14", 1'b0, 4'd14, 16'h0014, 16'h4000);
    tick();
    chkIdle("con.end", 16'h0000);

    // 5. r0 discard and hazard tracking on r9
    alu_valid = 1'b1; alu_rd = 4'd0; alu_data = 16'hDEAD;
    tick();
    chkIdle("r0.acc", 16'h0000);
    alu_rd = 4'd9; alu_data = 16'h0909;
    tick();
    chkIdle("r0.none", 16'h0200);
    alu_valid = 1'b0;
    tick();
    chkWrite("haz.w9", 1'b1, 4'd9, 16'h0909, 16'h0200);
    tick();
    chkIdle("haz.clr", 16'h0000);

    // 6. Reset while FIFO full and holding register occupied
    alu_valid = 1'b1; alu_rd = 4'd6; alu_data = 16'h0066;
    mem_valid = 1'b1; mem_rd = 4'd4; mem_data = 16'h0044;
    tick();
    chkIdle("mrst.acc", 16'h0050);
    alu_rd = 4'd8; alu_data = 16'h0088;
    mem_rd = 4'd5; mem_data = 16'h0055;
    tick();
    chkWrite("mrst.m4", 1'b0, 4'd4, 16'h0044, 16'h0170);
    chk("mrst.full", {31'd0, alu_ready}, 32'd0);
    reset = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
    chkIdle("mrst.rst", 16'h0000);
    chk("mrst.data", {16'd0, WriteData}, 32'd0);
    chk("mrst.alu_ready", {31'd0, alu_ready}, 32'd1);
    reset = 1'b0;
    tick();
    chkIdle("mrst.post1", 16'h0000);
    tick();
    chkIdle("mrst.post2", 16'h0000);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
